// File: rtl/redmule_tiler_seq.sv
// redmule_tiler_seq: GEMM tiling calculator built on one shared restoring divider and one shift-add multiplier.
// Define REDMULE_TILER_CHECK_EN to short-circuit zero-size problems and raise error_o.
module redmule_tiler_seq #(
  parameter  int unsigned ARRAY_WIDTH  = 12,
  parameter  int unsigned ARRAY_HEIGHT = 4,
  parameter  int unsigned PIPE_REGS    = 3,
  parameter  int unsigned DIM_W        = 16,
  localparam int unsigned PW           = 3*DIM_W+1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             setback_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] m_size_i,
  input  logic [DIM_W-1:0] n_size_i,
  input  logic [DIM_W-1:0] k_size_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DIM_W-1:0] x_rows_iter_o,
  output logic [DIM_W-1:0] x_cols_iter_o,
  output logic [DIM_W-1:0] w_cols_iter_o,
  output logic [DIM_W:0]   w_rows_iter_o,
  output logic [DIM_W-1:0] x_rows_lftovr_o,
  output logic [DIM_W-1:0] x_cols_lftovr_o,
  output logic [DIM_W-1:0] w_rows_lftovr_o,
  output logic [DIM_W-1:0] w_cols_lftovr_o,
  output logic [DIM_W-1:0] tot_stores_o,
  output logic [PW-1:0]    tot_x_read_o,
  output logic [PW-1:0]    w_tot_len_o,
  output logic             error_o
);

  localparam int unsigned D   = ARRAY_HEIGHT * (PIPE_REGS + 1);
  localparam int unsigned C   = DIM_W + 1;
  localparam int unsigned CW  = $clog2(C);
  localparam int unsigned RW  = DIM_W + 2;
  localparam int unsigned P1W = 2 * DIM_W;

  typedef enum logic [3:0] {
    IDLE, DIV_M, DIV_N, DIV_K, DIV_NH, MUL_XW, MUL_XC, MUL_WR, DONE
  } state_e;

  state_e state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic [DIM_W-1:0] m_reg, n_reg, k_reg;
  logic [PW-1:0]    acc_reg, mcand_reg;
  logic [DIM_W:0]   sh_reg;

  logic [DIM_W-1:0] xr_iter_reg, xr_lft_reg, xc_iter_reg, xc_lft_reg;
  logic [DIM_W-1:0] wc_iter_reg, wc_lft_reg, wr_lft_reg;
  logic [DIM_W:0]   wr_iter_reg;
  logic [P1W-1:0]   p1_reg;
  logic [PW-1:0]    txr_reg, wtl_reg;

  logic             last, is_div, chk_skip, div_ge;
  logic [RW-1:0]    divisor, div_shift, div_rem;
  logic [DIM_W:0]   div_quo, wr_iter_next;
  logic [DIM_W-1:0] q_lo, r_lo, ceil_q;
  logic [PW-1:0]    mul_sum;

  assign last   = (cnt_reg == CW'(C - 1));
  assign is_div = (state_reg == DIV_M) || (state_reg == DIV_N) ||
                  (state_reg == DIV_K) || (state_reg == DIV_NH);

  always_comb begin
    divisor = RW'(D);
    case (state_reg)
      DIV_M:   divisor = RW'(ARRAY_WIDTH);
      DIV_NH:  divisor = RW'(ARRAY_HEIGHT);
      default: divisor = RW'(D);
    endcase
  end

  // Restoring step: the dividend shifts out of sh_reg MSB-first while quotient bits shift in at the LSB.
  assign div_shift    = {acc_reg[RW-2:0], sh_reg[DIM_W]};
  assign div_ge       = (div_shift >= divisor);
  assign div_rem      = div_ge ? (div_shift - divisor) : div_shift;
  assign div_quo      = {sh_reg[DIM_W-1:0], div_ge};
  assign q_lo         = div_quo[DIM_W-1:0];
  assign r_lo         = div_rem[DIM_W-1:0];
  assign ceil_q       = q_lo + DIM_W'(r_lo != '0);
  assign wr_iter_next = (r_lo != '0) ? ({1'b0, n_reg} + (DIM_W+1)'(ARRAY_HEIGHT) - {1'b0, r_lo})
                                     : {1'b0, n_reg};
  assign mul_sum      = acc_reg + (sh_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = DIV_M;
      DIV_M:   if (chk_skip) state_next = DONE;
               else if (last) state_next = DIV_N;
      DIV_N:   if (last) state_next = DIV_K;
      DIV_K:   if (last) state_next = DIV_NH;
      DIV_NH:  if (last) state_next = MUL_XW;
      MUL_XW:  if (last) state_next = MUL_XC;
      MUL_XC:  if (last) state_next = MUL_WR;
      MUL_WR:  if (last) state_next = DONE;
      DONE:    if (ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_i || setback_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg     <= '0;
      m_reg       <= '0;
      n_reg       <= '0;
      k_reg       <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      sh_reg      <= '0;
      xr_iter_reg <= '0;
      xr_lft_reg  <= '0;
      xc_iter_reg <= '0;
      xc_lft_reg  <= '0;
      wc_iter_reg <= '0;
      wc_lft_reg  <= '0;
      wr_iter_reg <= '0;
      wr_lft_reg  <= '0;
      p1_reg      <= '0;
      txr_reg     <= '0;
      wtl_reg     <= '0;
    end else if (clear_i) begin
      cnt_reg     <= '0;
      xr_iter_reg <= '0;
      xr_lft_reg  <= '0;
      xc_iter_reg <= '0;
      xc_lft_reg  <= '0;
      wc_iter_reg <= '0;
      wc_lft_reg  <= '0;
      wr_iter_reg <= '0;
      wr_lft_reg  <= '0;
      p1_reg      <= '0;
      txr_reg     <= '0;
      wtl_reg     <= '0;
    end else if (setback_i) begin
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (start_i) begin
            m_reg   <= m_size_i;
            n_reg   <= n_size_i;
            k_reg   <= k_size_i;
            acc_reg <= '0;
            sh_reg  <= {1'b0, m_size_i};
          end
        end
        DONE: cnt_reg <= '0;
        default: begin
          cnt_reg <= last ? '0 : cnt_reg + CW'(1);
          if (is_div) begin
            acc_reg <= PW'(div_rem);
            sh_reg  <= div_quo;
          end else begin
            acc_reg   <= mul_sum;
            mcand_reg <= mcand_reg << 1;
            sh_reg    <= sh_reg >> 1;
          end
          // Phase end: commit this phase's result and preload the operands of the next one.
          if (last) begin
            acc_reg <= '0;
            case (state_reg)
              DIV_M: begin
                xr_iter_reg <= ceil_q;
                xr_lft_reg  <= r_lo;
                sh_reg      <= {1'b0, n_reg};
              end
              DIV_N: begin
                xc_iter_reg <= ceil_q;
                xc_lft_reg  <= r_lo;
                sh_reg      <= {1'b0, k_reg};
              end
              DIV_K: begin
                wc_iter_reg <= ceil_q;
                wc_lft_reg  <= r_lo;
                sh_reg      <= {1'b0, n_reg};
              end
              DIV_NH: begin
                wr_lft_reg  <= r_lo;
                wr_iter_reg <= wr_iter_next;
                mcand_reg   <= PW'(xr_iter_reg);
                sh_reg      <= {1'b0, wc_iter_reg};
              end
              MUL_XW: begin
                p1_reg    <= mul_sum[P1W-1:0];
                mcand_reg <= PW'(mul_sum[P1W-1:0]);
                sh_reg    <= {1'b0, xc_iter_reg};
              end
              MUL_XC: begin
                txr_reg   <= mul_sum;
                mcand_reg <= PW'(p1_reg);
                sh_reg    <= wr_iter_reg;
              end
              MUL_WR:  wtl_reg <= mul_sum;
              default: ;
            endcase
          end
        end
      endcase
      if (state_reg == DIV_M && chk_skip) begin
        cnt_reg     <= '0;
        xr_iter_reg <= '0;
        xr_lft_reg  <= '0;
        xc_iter_reg <= '0;
        xc_lft_reg  <= '0;
        wc_iter_reg <= '0;
        wc_lft_reg  <= '0;
        wr_iter_reg <= '0;
        wr_lft_reg  <= '0;
        p1_reg      <= '0;
        txr_reg     <= '0;
        wtl_reg     <= '0;
      end
    end
  end

`ifdef REDMULE_TILER_CHECK_EN
  logic err_reg;

  assign chk_skip = (m_reg == '0) || (n_reg == '0) || (k_reg == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             err_reg <= 1'b0;
    else if (clear_i || setback_i)           err_reg <= 1'b0;
    else if (state_reg == DIV_M && chk_skip) err_reg <= 1'b1;
    else if (state_reg == DONE && ready_i)   err_reg <= 1'b0;
  end

  assign error_o = err_reg;
`else
  assign chk_skip = 1'b0;
  assign error_o  = 1'b0;
`endif

  assign busy_o          = (state_reg != IDLE);
  assign valid_o         = (state_reg == DONE);
  assign x_rows_iter_o   = xr_iter_reg;
  assign x_rows_lftovr_o = xr_lft_reg;
  assign x_cols_iter_o   = xc_iter_reg;
  assign x_cols_lftovr_o = xc_lft_reg;
  assign w_cols_iter_o   = wc_iter_reg;
  assign w_cols_lftovr_o = wc_lft_reg;
  assign w_rows_iter_o   = wr_iter_reg;
  assign w_rows_lftovr_o = wr_lft_reg;
  assign tot_stores_o    = p1_reg[DIM_W-1:0];
  assign tot_x_read_o    = txr_reg;
  assign w_tot_len_o     = wtl_reg;

endmodule

// File: doc/redmule_tiler_seq.md
# redmule_tiler_seq

Parametrised, area-reduced successor of the RedMulE tiling calculator. It turns a GEMM problem size (M, N, K) into tile iteration counts, leftovers and loop-length products for a configurable array geometry (ARRAY_WIDTH, ARRAY_HEIGHT, PIPE_REGS, DIM_W). All division and multiplication runs on one shared sequential divider and one shared shift-add multiplier, with no combinational dividers. It sits between the control register file and the scheduler, and results are returned through a valid/ready handshake.

## Interface
- ARRAY_WIDTH, default 12: array columns; divisor for M; must be ≥2.
- ARRAY_HEIGHT, default 4: array rows; divisor for the N-row leftover; must be ≥1.
- PIPE_REGS, default 3: FMA pipeline registers; D = ARRAY_HEIGHT*(PIPE_REGS+1) is the divisor for N and K.
- DIM_W, default 16: width of M, N and K. PW = 3*DIM_W+1.
- clk_i, input, 1: clock.
- rst_ni, input, 1: reset, asynchronous, active-low.
- clear_i, input, 1: synchronous abort; zeroes all results.
- setback_i, input, 1: synchronous abort; keeps result registers.
- start_i, input, 1: starts a computation; accepted only in IDLE.
- m_size_i, n_size_i, k_size_i, input, DIM_W each: problem size; sampled on start.
- busy_o, output, 1: high whenever the state is not IDLE.
- valid_o, output, 1: results are valid.
- ready_i, input, 1: consumer accepts the results.
- x_rows_iter_o, x_cols_iter_o, w_cols_iter_o, output, DIM_W each.
- w_rows_iter_o, output, DIM_W+1.
- x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o, output, DIM_W each.
- tot_stores_o, output, DIM_W: low bits of P1.
- tot_x_read_o, w_tot_len_o, output, PW each.
- error_o, output, 1: zero-size problem; present only with the configuration macro defined, otherwise tied to 0.

## Operation
- Definitions, with q/r as the quotient/remainder and ceil(a,b) = q + (r≠0):
  - x_rows_iter = ceil(M, ARRAY_WIDTH); x_rows_lftovr = M mod ARRAY_WIDTH.
  - x_cols_iter = ceil(N, D); x_cols_lftovr = N mod D.
  - w_cols_iter = ceil(K, D); w_cols_lftovr = K mod D.
  - w_rows_lftovr = N mod ARRAY_HEIGHT; w_rows_iter = lftovr≠0 ? N + ARRAY_HEIGHT − lftovr : N, computed in DIM_W+1 bits with no wrap.
  - P1 = x_rows_iter*w_cols_iter (2*DIM_W bits); tot_stores = P1[DIM_W-1:0].
  - tot_x_read = P1*x_cols_iter; w_tot_len = P1*w_rows_iter; both are exact in PW bits.
- FSM states: IDLE → DIV_M → DIV_N → DIV_K → DIV_NH → MUL_XW → MUL_XC → MUL_WR → DONE.
- Each DIV_*/MUL_* state lasts exactly C = DIM_W+1 cycles, counted by a shared counter.
  - Divider: restoring, one quotient bit per cycle.
  - Multiplier: shift-add, one multiplier bit per cycle; the multiplier operand is DIM_W+1 bits, zero-extended.
- DONE holds valid_o=1 with stable outputs until ready_i=1, then moves to IDLE.
- start_i outside IDLE is ignored.
- Abort priority: clear_i > setback_i > everything else.
  - Either abort, in any state, forces IDLE and valid_o=0 on the next edge.
  - clear_i also zeroes all result registers; setback_i leaves them unchanged.
- Input sizes are latched on start and are not re-read mid-operation.
- M, N or K equal to 0 uses the formulas above: the iteration count is 0 and the products are 0.

## Timing
- Reset value: every output 0, state IDLE.
- start_i is sampled at edge t in IDLE. busy_o is high from t. valid_o is high from edge t + 7*C; default latency is 119 cycles.
- Handshake: transfer occurs when valid_o && ready_i at edge u. valid_o and busy_o are low after u.
- A new start is accepted at the earliest at u+1; start_i at u itself is ignored.
- Outputs change only at the end of the phase that produces them. All outputs are stable while valid_o=1.

## Configuration
- REDMULE_TILER_CHECK_EN defined:
  - A start with M, N or K equal to 0 skips the compute states: IDLE → DONE in 1 cycle.
  - All result outputs are 0, and error_o=1 alongside valid_o.
  - error_o clears on the handshake or on abort.
- Macro undefined: no check; zero sizes take the full 7*C latency; error_o=0.

## Test plan
- Defaults; M=N=K=32.
  - valid_o at start+119.
  - x_rows 3/8, x_cols 2/0, w_cols 2/0, w_rows 32/0.
  - tot_stores 6, tot_x_read 12, w_tot_len 192.
- M=13, N=17, K=5.
  - x_rows 2/1, x_cols 2/1, w_cols 1/5, w_rows 20/1.
  - tot_stores 2, tot_x_read 4, w_tot_len 40.
- M=N=K=65535.
  - x_rows 5462/3, x_cols 4096/15, w_cols 4096/15, w_rows 65536/3.
  - tot_stores 24576, tot_x_read 91637153792, w_tot_len 1466194460672.
- M=0, N=K=16.
  - With the macro: valid_o at start+1, error_o=1, all results 0.
  - Without the macro: valid_o at start+119, error_o=0, x_rows 0/0, x_cols 1/0.
- Run M=N=K=32 with ready_i held low for 10 cycles: valid_o and outputs stay stable.
  - Handshake then start in the same cycle: that start is ignored; a start one cycle later is accepted.
- setback_i at start+50 during a second run: IDLE and valid_o=0 next edge, previous results retained.
  - A following clear_i zeroes all outputs.
  - A start_i pulse during busy has no effect.
